markov_update_scheduler: RTL and testbench

MARKOV_UPDATE_SCHEDULER -- requirements
Module: markov_update_scheduler

---
 rtl/markov_update_scheduler_if.sv | 13 +
 rtl/markov_update_scheduler.sv | 123 ++++++++++++
 tb/tb_markov_update_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/markov_update_scheduler_if.sv
// Request/acknowledge bundle between the four fragment streams and the scheduler.
interface markov_update_scheduler_if #(
  parameter int SEQ_W = 32
) ();
  logic [3:0]         req;
  logic [4*SEQ_W-1:0] seq_in;
  logic [3:0]         ack;
  logic               hit;
  logic               drop;

  modport master (output req, seq_in, input ack, hit, drop);
  modport slave  (input req, seq_in, output ack, hit, drop);
endinterface

// File: rtl/markov_update_scheduler.sv
// Round-robin arbiter feeding a linear-search Markov sequence occurrence table.
module markov_update_scheduler #(
  parameter int NOTE_BIT_LEN    = 8,
  parameter int DELAY_BIT_LEN   = 8,
  parameter int SEQUENCE_LEN    = 2,
  parameter int SEQ_CNT_BIT_LEN = 8,
  parameter int TABLE_DEPTH     = 16,
  localparam int SEQ_W = SEQUENCE_LEN * (NOTE_BIT_LEN + DELAY_BIT_LEN),
  localparam int IDX_W = $clog2(TABLE_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  markov_update_scheduler_if.slave     bus,
  output logic                         busy,
  output logic [IDX_W:0]               used,
  input  logic [IDX_W-1:0]             rd_addr,
  output logic [SEQ_W-1:0]             rd_seq,
  output logic [SEQ_CNT_BIT_LEN-1:0]   rd_cnt
);

  typedef enum logic [2:0] {IDLE, SEARCH, UPDATE, INSERT, ACK} state_t;

  localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(TABLE_DEPTH);

  state_t                      state;
  logic [SEQ_W-1:0]            tbl_seq [TABLE_DEPTH];
  logic [SEQ_CNT_BIT_LEN-1:0]  tbl_cnt [TABLE_DEPTH];
  logic [1:0]                  rr_ptr;
  logic [1:0]                  g;
  logic [SEQ_W-1:0]            cur;
  logic [IDX_W:0]              idx;

  logic                        gnt_valid;
  logic [1:0]                  gnt_idx;
  logic [1:0]                  cand;

  // Cyclic priority search starting at rr_ptr.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int unsigned off = 0; off < 4; off++) begin
      cand = rr_ptr + 2'(off);
      if (!gnt_valid && bus.req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      used     <= '0;
      rr_ptr   <= '0;
      g        <= '0;
      cur      <= '0;
      idx      <= '0;
      bus.ack  <= '0;
      bus.hit  <= 1'b0;
      bus.drop <= 1'b0;
      rd_seq   <= '0;
      rd_cnt   <= '0;
      for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
        tbl_seq[i] <= '0;
        tbl_cnt[i] <= '0;
      end
    end else begin
      rd_seq <= ({1'b0, rd_addr} < used) ? tbl_seq[rd_addr] : '0;
      rd_cnt <= ({1'b0, rd_addr} < used) ? tbl_cnt[rd_addr] : '0;

      case (state)
        IDLE: begin
          if (gnt_valid) begin
            g     <= gnt_idx;
            cur   <= bus.seq_in[gnt_idx*SEQ_W +: SEQ_W];
            idx   <= '0;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (used == '0)
            state <= INSERT;
          else if (tbl_seq[idx[IDX_W-1:0]] == cur)
            state <= UPDATE;
          else if (idx == used - 1'b1)
            state <= INSERT;
          else
            idx <= idx + 1'b1;
        end
        UPDATE: begin
          if (tbl_cnt[idx[IDX_W-1:0]] != '1)
            tbl_cnt[idx[IDX_W-1:0]] <= tbl_cnt[idx[IDX_W-1:0]] + 1'b1;
          bus.hit <= 1'b1;
          bus.ack <= 4'b0001 << g;
          state   <= ACK;
        end
        INSERT: begin
          if (used < DEPTH) begin
            tbl_seq[used[IDX_W-1:0]] <= cur;
            tbl_cnt[used[IDX_W-1:0]] <= SEQ_CNT_BIT_LEN'(1);
            used <= used + 1'b1;
          end else begin
            bus.drop <= 1'b1;
          end
          bus.ack <= 4'b0001 << g;
          state   <= ACK;
        end
        ACK: begin
          bus.ack  <= '0;
          bus.hit  <= 1'b0;
          bus.drop <= 1'b0;
          rr_ptr   <= g + 2'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_markov_update_scheduler.sv
// Randomized bench with a queue-based occurrence-table model and round-robin grant model.
module tb_markov_update_scheduler;
  localparam int TD = 16;
  localparam int SW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          busy;
  logic [IW:0]   used;
  logic [IW-1:0] rd_addr;
  logic [SW-1:0] rd_seq;
  logic [7:0]    rd_cnt;

  markov_update_scheduler_if #(.SEQ_W(SW)) bus ();

  markov_update_scheduler #(
    .NOTE_BIT_LEN(8), .DELAY_BIT_LEN(8), .SEQUENCE_LEN(2),
    .SEQ_CNT_BIT_LEN(8), .TABLE_DEPTH(TD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .used(used),
    .rd_addr(rd_addr), .rd_seq(rd_seq), .rd_cnt(rd_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] m_seq[$];
  int            m_cnt[$];
  int            m_rr;

  function automatic void m_clear();
    m_seq.delete();
    m_cnt.delete();
    m_rr = 0;
  endfunction

  // Applies one operation to the model; returns expected grant-to-ack latency.
  function automatic int model_apply(input logic [SW-1:0] s, output logic h, output logic d);
    int u;
    h = 1'b0;
    d = 1'b0;
    foreach (m_seq[k]) begin
      if (m_seq[k] == s) begin
        h = 1'b1;
        if (m_cnt[k] < 255) m_cnt[k]++;
        return k + 3;
      end
    end
    u = m_seq.size();
    if (u < TD) begin
      m_seq.push_back(s);
      m_cnt.push_back(1);
    end else begin
      d = 1'b1;
    end
    return ((u > 0) ? u : 1) + 2;
  endfunction

  function automatic int model_grant(input logic [3:0] pend);
    for (int off = 0; off < 4; off++)
      if (pend[(m_rr + off) % 4]) return (m_rr + off) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_seq(input int i, input logic [SW-1:0] s);
    bus.seq_in[i*SW +: SW] = s;
  endtask

  // Waits (bounded) for an ack; lat counts rising edges from the call.
  task automatic wait_ack(output logic [3:0] a, output logic h, output logic d,
                          output int lat, output logic bad);
    a = '0; h = 1'b0; d = 1'b0; lat = 0; bad = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.ack == '0 && (bus.hit || bus.drop)) bad = 1'b1;
      if (bus.ack != '0) begin
        a = bus.ack; h = bus.hit; d = bus.drop;
        if (h && d) bad = 1'b1;
        return;
      end
    end
  endtask

  task automatic single_op(input int g, input logic [SW-1:0] s, output logic [3:0] a,
                           output logic h, output logic d, output int lat, output logic bad);
    set_seq(g, s);
    bus.req[g] = 1'b1;
    wait_ack(a, h, d, lat, bad);
    bus.req[g] = 1'b0;
    @(negedge clk);
    m_rr = (g + 1) % 4;
  endtask

  task automatic read_entry(input int i, output logic [SW-1:0] s, output logic [7:0] c);
    rd_addr = IW'(i);
    @(posedge clk);
    @(negedge clk);
    s = rd_seq;
    c = rd_cnt;
  endtask

  task automatic test_reset();
    logic [SW-1:0] s; logic [7:0] c;
    do_reset();
    m_clear();
    checks++; if (bus.ack !== 4'b0 || bus.hit !== 1'b0 || bus.drop !== 1'b0) begin errors++;
      $display("FAIL reset_outputs ack=%b hit=%b drop=%b need 0000/0/0", bus.ack, bus.hit, bus.drop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b need 0", busy); end
    checks++; if (used !== '0) begin errors++; $display("FAIL reset_used got %0d need 0", used); end
    read_entry(0, s, c);
    checks++; if (s !== '0 || c !== '0) begin errors++;
      $display("FAIL reset_read seq=%h cnt=%0d need 0/0", s, c); end
  endtask

  task automatic test_basic();
    logic [SW-1:0] a_seq, s; logic [7:0] c; logic [3:0] a; logic h, d, eh, ed, bad; int lat, el;
    a_seq = $urandom;
    el = model_apply(a_seq, eh, ed);
    single_op(0, a_seq, a, h, d, lat, bad);
    checks++; if (a !== 4'b0001 || h !== 1'b0 || d !== 1'b0 || lat != 3 || el != 3) begin errors++;
      $display("FAIL first_insert ack=%b hit=%b drop=%b lat=%0d need 0001/0/0/3", a, h, d, lat); end
    checks++; if (used !== 5'd1) begin errors++; $display("FAIL first_used got %0d need 1", used); end
    read_entry(0, s, c);
    checks++; if (s !== a_seq || c !== 8'd1) begin errors++;
      $display("FAIL first_read seq=%h cnt=%0d need %h/1", s, c, a_seq); end
    el = model_apply(a_seq, eh, ed);
    single_op(2, a_seq, a, h, d, lat, bad);
    checks++; if (a !== 4'b0100 || h !== 1'b1 || d !== 1'b0 || lat != el || bad !== 1'b0) begin errors++;
      $display("FAIL repeat_hit ack=%b hit=%b drop=%b lat=%0d need 0100/1/0/%0d", a, h, d, lat, el); end
    read_entry(0, s, c);
    checks++; if (c !== 8'd2 || used !== 5'd1) begin errors++;
      $display("FAIL repeat_read cnt=%0d used=%0d need 2/1", c, used); end
  endtask

  task automatic test_round_robin();
    logic [3:0] pend, a; logic h, d, eh, ed, bad; int lat, el, eg;
    do_reset();
    m_clear();
    for (int i = 0; i < 4; i++) set_seq(i, SW'(32'h1000 + i * 7));
    pend = 4'b1111;
    bus.req = pend;
    for (int i = 0; i < 4; i++) begin
      eg = model_grant(pend);
      el = model_apply(bus.seq_in[eg*SW +: SW], eh, ed) + ((i == 0) ? 0 : 1);
      wait_ack(a, h, d, lat, bad);
      checks++; if (a !== (4'b0001 << i) || eg != i || h !== eh || d !== ed || lat != el || bad !== 1'b0) begin
        errors++;
        $display("FAIL rr_order_%0d ack=%b hit=%b lat=%0d need %b/%b/%0d", i, a, h, lat, 4'b0001 << i, eh, el);
      end
      if (a == '0) break;
      pend[eg] = 1'b0;
      bus.req[eg] = 1'b0;
      m_rr = (eg + 1) % 4;
    end
    @(negedge clk);
    checks++; if (used !== 5'd4) begin errors++; $display("FAIL rr_used got %0d need 4", used); end
  endtask

  task automatic test_seq_latch();
    logic [SW-1:0] x, y, s; logic [7:0] c; logic [3:0] a; logic h, d, eh, ed, bad; int lat;
    do_reset();
    m_clear();
    x = 32'hA5A5_0001; y = 32'h5A5A_0002;
    set_seq(1, x);
    bus.req[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_seq(1, y);
    bus.req[1] = 1'b0;
    void'(model_apply(x, eh, ed));
    wait_ack(a, h, d, lat, bad);
    checks++; if (a !== 4'b0010 || lat + 1 != 3 || h !== 1'b0) begin errors++;
      $display("FAIL latch_ack ack=%b lat=%0d need 0010/3", a, lat + 1); end
    @(negedge clk);
    read_entry(0, s, c);
    checks++; if (s !== x || c !== 8'd1) begin errors++;
      $display("FAIL latch_seq seq=%h cnt=%0d need %h/1", s, c, x); end
  endtask

  task automatic test_full();
    logic [SW-1:0] s; logic [7:0] c; logic [3:0] a; logic h, d, eh, ed, bad; int lat, el, nd;
    do_reset();
    m_clear();
    nd = 0;
    for (int i = 0; i < TD; i++) begin
      void'(model_apply(SW'(32'hBEEF_0000 + i), eh, ed));
      single_op(i % 4, SW'(32'hBEEF_0000 + i), a, h, d, lat, bad);
      if (d || h || a == '0) nd++;
    end
    checks++; if (nd != 0 || used !== 5'd16) begin errors++;
      $display("FAIL fill used=%0d bad_acks=%0d need 16/0", used, nd); end
    el = model_apply(32'hDEAD_0000, eh, ed);
    single_op(1, 32'hDEAD_0000, a, h, d, lat, bad);
    checks++; if (a !== 4'b0010 || d !== 1'b1 || h !== 1'b0 || ed !== 1'b1 || lat != el) begin errors++;
      $display("FAIL full_drop ack=%b drop=%b hit=%b lat=%0d need 0010/1/0/%0d", a, d, h, lat, el); end
    checks++; if (used !== 5'd16) begin errors++; $display("FAIL full_used got %0d need 16", used); end
    for (int i = 0; i < TD; i++) begin
      read_entry(i, s, c);
      checks++; if (s !== m_seq[i] || c !== 8'(m_cnt[i])) begin errors++;
        $display("FAIL full_table_%0d seq=%h cnt=%0d need %h/%0d", i, s, c, m_seq[i], m_cnt[i]); end
    end
    el = model_apply(m_seq[5], eh, ed);
    single_op(3, m_seq[5], a, h, d, lat, bad);
    checks++; if (a !== 4'b1000 || h !== 1'b1 || d !== 1'b0 || lat != el || el != 8) begin errors++;
      $display("FAIL full_hit ack=%b hit=%b drop=%b lat=%0d need 1000/1/0/8", a, h, d, lat); end
  endtask

  task automatic test_saturate();
    logic [SW-1:0] s, sq; logic [7:0] c; logic [3:0] a; logic h, d, eh, ed, bad; int lat, nmiss;
    do_reset();
    m_clear();
    sq = $urandom;
    nmiss = 0;
    for (int i = 0; i < 300; i++) begin
      void'(model_apply(sq, eh, ed));
      single_op(i % 4, sq, a, h, d, lat, bad);
      if (a == '0 || h !== eh) nmiss++;
    end
    checks++; if (nmiss != 0) begin errors++; $display("FAIL sat_ops got %0d bad ops need 0", nmiss); end
    read_entry(0, s, c);
    checks++; if (c !== 8'd255 || m_cnt[0] != 255 || used !== 5'd1) begin errors++;
      $display("FAIL sat_cnt cnt=%0d used=%0d need 255/1", c, used); end
  endtask

  task automatic test_random();
    logic [SW-1:0] pool [24]; logic [SW-1:0] s; logic [7:0] c;
    logic [3:0] pend, a; logic h, d, eh, ed, bad; int lat, el, eg, nerr;
    do_reset();
    m_clear();
    for (int i = 0; i < 24; i++) pool[i] = SW'({$urandom_range(0, 65535), 16'(i)});
    nerr = 0;
    for (int b = 0; b < 40; b++) begin
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) set_seq(i, pool[$urandom_range(0, 23)]);
      bus.req = pend;
      for (int n = 0; pend != '0; n++) begin
        eg = model_grant(pend);
        el = model_apply(bus.seq_in[eg*SW +: SW], eh, ed) + ((n == 0) ? 0 : 1);
        wait_ack(a, h, d, lat, bad);
        checks++; if (a !== (4'b0001 << eg) || h !== eh || d !== ed || lat != el || bad !== 1'b0) begin
          errors++; nerr++;
          $display("FAIL rand_op_%0d_%0d ack=%b hit=%b drop=%b lat=%0d need %b/%b/%b/%0d",
                   b, n, a, h, d, lat, 4'b0001 << eg, eh, ed, el);
        end
        if (a == '0) break;
        pend[eg] = 1'b0;
        bus.req[eg] = 1'b0;
        m_rr = (eg + 1) % 4;
      end
      bus.req = '0;
      @(negedge clk);
      checks++; if (used !== 5'(m_seq.size())) begin errors++;
        $display("FAIL rand_used_%0d got %0d need %0d", b, used, m_seq.size()); end
      if (nerr > 5) break;
    end
    for (int i = 0; i < TD; i++) begin
      read_entry(i, s, c);
      checks++; if (i < m_seq.size() ? (s !== m_seq[i] || c !== 8'(m_cnt[i])) : (s !== '0 || c !== '0)) begin
        errors++; $display("FAIL rand_table_%0d seq=%h cnt=%0d", i, s, c); end
    end
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] s; logic [7:0] c; logic [3:0] a; logic h, d, bad; int lat, seen;
    do_reset();
    m_clear();
    for (int i = 0; i < 3; i++) single_op(0, SW'(32'h7700 + i), a, h, d, lat, bad);
    set_seq(0, 32'h7799);
    bus.req[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b need 1", busy); end
    rst_n = 1'b0;
    bus.req = '0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || used !== '0 || bus.ack !== '0) begin errors++;
      $display("FAIL mid_reset busy=%b used=%0d ack=%b need 0/0/0000", busy, used, bus.ack); end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.ack != '0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_ack got %0d acks need 0", seen); end
    read_entry(0, s, c);
    checks++; if (s !== '0 || c !== '0) begin errors++;
      $display("FAIL mid_table seq=%h cnt=%0d need 0/0", s, c); end
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr = '0;
    bus.req = '0;
    bus.seq_in = '0;
    m_clear();
    test_reset();
    test_basic();
    test_round_robin();
    test_seq_latch();
    test_full();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
